rptr_empty: RTL and testbench

- Read-side pointer and empty-flag generator for the async FIFO. Lives entirely in the read clock domain.
- Mirrors the write-side pointer: the pointer runs over binary range 9..54 (46 slots, 45 usable entries) and is published as Gray code to the write domain.
- Consumes the write pointer after it has passed through the 2-flop synchronizer. Produces empty, memory read address, occupancy level, almost-empty and a sticky underflow flag.

---
 rtl/rptr_empty.sv | 178 +++++++++++++++++
 tb/tb_rptr_empty.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rptr_empty.sv
// rptr_empty: read-side pointer and empty-flag generator for the async FIFO.
// Everything here runs in the read clock domain. The binary read pointer
// walks PTR_MIN..PTR_MAX and wraps back to PTR_MIN. It is published as Gray
// code to the write domain. The synchronized Gray write pointer is decoded
// here to produce empty, the occupancy level, almost-empty and a sticky
// underflow flag.
//
// The pointer range is symmetric around the middle of the PTR_W-bit space,
// because PTR_MIN + PTR_MAX == 2**PTR_W - 1. As a result, the Gray codes of
// PTR_MAX and PTR_MIN differ only in the MSB, and the wrap is still a
// single-bit change as seen by the write-domain synchronizer.

module rptr_empty #(
  parameter int PTR_W     = 6,
  parameter int PTR_MIN   = 9,
  parameter int PTR_MAX   = 54,
  parameter int AE_THRESH = 4
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             ren,
  input  logic [PTR_W-1:0] g_wptr_sync,
  output logic [PTR_W-1:0] b_rptr,
  output logic [PTR_W-1:0] g_rptr,
  output logic [PTR_W-1:0] raddr,
  output logic             empty,
  output logic [PTR_W-1:0] rd_level,
  output logic             almost_empty,
  output logic             underflow
);

  // Pointer ranges that are not symmetric would break the one-bit Gray wrap.
  if (PTR_MIN + PTR_MAX != (1 << PTR_W) - 1) begin : g_bad_range
    $fatal(1, "rptr_empty: PTR_MIN + PTR_MAX must equal 2**PTR_W - 1");
  end

  localparam logic [PTR_W-1:0] L_MIN  = PTR_W'(PTR_MIN);
  localparam logic [PTR_W-1:0] L_MAX  = PTR_W'(PTR_MAX);
  localparam logic [PTR_W-1:0] L_AE   = PTR_W'(AE_THRESH);
  localparam logic [PTR_W:0]   L_SPAN = (PTR_W+1)'(PTR_MAX - PTR_MIN + 1);

  // Binary to Gray conversion.
  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary conversion: each binary bit is the XOR of all Gray bits at
  // that position and above.
  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = g[i] ^ b[i+1];
    end
    return b;
  endfunction

  // Distance from the read pointer to the write pointer around the ring.
  // The subtraction is done one bit wider so that the wrapped case can add
  // the ring span before truncation.
  function automatic logic [PTR_W-1:0] ring_diff(input logic [PTR_W-1:0] w,
                                                 input logic [PTR_W-1:0] r);
    logic [PTR_W:0] d;
    if (w >= r) begin
      d = {1'b0, w} - {1'b0, r};
    end else begin
      d = {1'b0, w} - {1'b0, r} + L_SPAN;
    end
    return d[PTR_W-1:0];
  endfunction

  logic [PTR_W-1:0] r_b_rptr;
  logic [PTR_W-1:0] r_g_rptr;
  logic [PTR_W-1:0] r_raddr;
  logic [PTR_W-1:0] r_level;
  logic             r_ae;
  logic             r_uf;

  logic [PTR_W-1:0] w_wptr_bin;
  logic             w_empty;
  logic             w_accept;
  logic [PTR_W-1:0] w_rptr_inc;
  logic [PTR_W-1:0] w_rptr_nxt;
  logic [PTR_W-1:0] w_diff;

  // Decode the write pointer, detect empty, and form the next read pointer and its occupancy.
  always_comb begin
    w_wptr_bin = gray2bin(g_wptr_sync);
    w_empty    = (r_b_rptr == w_wptr_bin);
    w_accept   = ren && !w_empty;
    if (r_b_rptr == L_MAX) begin
      w_rptr_inc = L_MIN;
    end else begin
      w_rptr_inc = r_b_rptr + PTR_W'(1);
    end
    if (w_accept) begin
      w_rptr_nxt = w_rptr_inc;
    end else begin
      w_rptr_nxt = r_b_rptr;
    end
    w_diff = ring_diff(w_wptr_bin, w_rptr_nxt);
  end

  // Pointer, its Gray/address views, level, almost-empty and sticky underflow.
  // The Gray code and the address are registered from the next pointer, so
  // they track b_rptr exactly and reach the synchronizer glitch-free.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_b_rptr <= L_MIN;
      r_g_rptr <= bin2gray(L_MIN);
      r_raddr  <= '0;
      r_level  <= '0;
      r_ae     <= 1'b1;
      r_uf     <= 1'b0;
    end else begin
      r_b_rptr <= w_rptr_nxt;
      r_g_rptr <= bin2gray(w_rptr_nxt);
      r_raddr  <= w_rptr_nxt - L_MIN;
      r_level  <= w_diff;
      r_ae     <= (w_diff <= L_AE);
      r_uf     <= r_uf | (ren & w_empty);
    end
  end

  assign b_rptr       = r_b_rptr;
  assign g_rptr       = r_g_rptr;
  assign raddr        = r_raddr;
  assign empty        = w_empty;
  assign rd_level     = r_level;
  assign almost_empty = r_ae;
  assign underflow    = r_uf;

  rptr_empty_chk #(
    .PTR_W   (PTR_W),
    .PTR_MIN (PTR_MIN),
    .PTR_MAX (PTR_MAX)
  ) u_chk (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .b_rptr   (r_b_rptr),
    .g_rptr   (r_g_rptr),
    .rd_level (r_level),
    .empty    (w_empty)
  );

endmodule

// rptr_empty_chk: structural invariants of the read pointer logic.
module rptr_empty_chk #(
  parameter int PTR_W   = 6,
  parameter int PTR_MIN = 9,
  parameter int PTR_MAX = 54
) (
  input logic             rclk,
  input logic             rrst_n,
  input logic [PTR_W-1:0] b_rptr,
  input logic [PTR_W-1:0] g_rptr,
  input logic [PTR_W-1:0] rd_level,
  input logic             empty
);

  localparam logic [PTR_W-1:0] L_MIN     = PTR_W'(PTR_MIN);
  localparam logic [PTR_W-1:0] L_MAX     = PTR_W'(PTR_MAX);
  localparam logic [PTR_W-1:0] L_LVL_MAX = PTR_W'(PTR_MAX - PTR_MIN);

  a_ptr_range: assert property (@(posedge rclk) disable iff (!rrst_n)
    (b_rptr >= L_MIN) && (b_rptr <= L_MAX));

  a_gray_one_bit: assert property (@(posedge rclk) disable iff (!rrst_n)
    $countones(g_rptr ^ $past(g_rptr)) <= 1);

  a_level_max: assert property (@(posedge rclk) disable iff (!rrst_n)
    rd_level <= L_LVL_MAX);

  a_no_adv_empty: assert property (@(posedge rclk) disable iff (!rrst_n)
    $past(empty) |-> (b_rptr == $past(b_rptr)));

endmodule

// File: tb/tb_rptr_empty.sv
// Testbench for rptr_empty. A ring-slot model tracks the read and write
// positions as integers 0..45, and expected outputs are derived from them.
module tb_rptr_empty;

  logic       rclk;
  logic       rst_n;
  logic       ren;
  logic [5:0] g_wptr_sync;
  logic [5:0] b_rptr;
  logic [5:0] g_rptr;
  logic [5:0] raddr;
  logic       empty;
  logic [5:0] rd_level;
  logic       almost_empty;
  logic       underflow;

  int total = 0;
  int bad   = 0;

  // Reference model state: slots counted from the first pointer value.
  int m_rslot, m_wslot, m_level;
  bit m_ae, m_uf;

  logic [26:0] obs;

  rptr_empty dut (
    .rclk         (rclk),
    .rrst_n       (rst_n),
    .ren          (ren),
    .g_wptr_sync  (g_wptr_sync),
    .b_rptr       (b_rptr),
    .g_rptr       (g_rptr),
    .raddr        (raddr),
    .empty        (empty),
    .rd_level     (rd_level),
    .almost_empty (almost_empty),
    .underflow    (underflow)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic int ring(input int x);
    return ((x % 46) + 46) % 46;
  endfunction

  function automatic logic [5:0] to_gray(input int slot);
    logic [5:0] b;
    b = 6'(slot + 9);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [26:0] exp_vec();
    logic [5:0] b;
    b = 6'(m_rslot + 9);
    return {b, b ^ (b >> 1), 6'(m_rslot), (ring(m_wslot - m_rslot) == 0),
            6'(m_level), m_ae, m_uf};
  endfunction

  task automatic set_in(input logic r, input int ws);
    ren         = r;
    m_wslot     = ring(ws);
    g_wptr_sync = to_gray(m_wslot);
  endtask

  task automatic model_reset();
    m_rslot = 0;
    m_level = 0;
    m_ae    = 1'b1;
    m_uf    = 1'b0;
  endtask

  // One rclk edge: advance the model with the inputs held across the edge.
  task automatic tick();
    int occ;
    @(posedge rclk);
    if (rst_n) begin
      occ = ring(m_wslot - m_rslot);
      if (ren) begin
        if (occ == 0) m_uf = 1'b1;
        else          m_rslot = (m_rslot + 1) % 46;
      end
      m_level = ring(m_wslot - m_rslot);
      m_ae    = (m_level <= 4);
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(1'b0, 0);
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    obs = {b_rptr, g_rptr, raddr, empty, rd_level, almost_empty, underflow};
    total++;
    if (obs !== exp_vec()) begin
      bad++;
      $display("FAIL reset_vec got=%h want=%h", obs, exp_vec());
    end
    total++;
    if (g_rptr !== 6'b001101) begin
      bad++;
      $display("FAIL reset_gray got=%b want=001101", g_rptr);
    end
  endtask

  task automatic test_burst();
    set_in(1'b0, 5);
    tick();
    total++;
    if (rd_level !== 6'd5 || almost_empty !== 1'b0) begin
      bad++;
      $display("FAIL burst_level got=%0d/%b want=5/0", rd_level, almost_empty);
    end
    for (int i = 0; i < 6; i++) begin
      set_in(i < 5, 5);
      tick();
      obs = {b_rptr, g_rptr, raddr, empty, rd_level, almost_empty, underflow};
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL burst[%0d] got=%h want=%h", i, obs, exp_vec());
      end
      if (i == 0) begin
        total++;
        if (g_rptr !== 6'b001111) begin
          bad++;
          $display("FAIL burst_gray got=%b want=001111", g_rptr);
        end
      end
    end
    total++;
    if (b_rptr !== 6'd14 || empty !== 1'b1) begin
      bad++;
      $display("FAIL burst_end got=%0d/%b want=14/1", b_rptr, empty);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 47; i++) begin
      set_in(1'b1, (i < 45) ? 45 : 1);
      tick();
      obs = {b_rptr, g_rptr, raddr, empty, rd_level, almost_empty, underflow};
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL wrap[%0d] got=%h want=%h", i, obs, exp_vec());
      end
      if (i == 45) begin
        total++;
        if (b_rptr !== 6'd9 || g_rptr !== 6'b001101 || raddr !== 6'd0) begin
          bad++;
          $display("FAIL wrap_edge got=%0d/%b/%0d want=9/001101/0", b_rptr, g_rptr, raddr);
        end
      end
    end
    total++;
    if (b_rptr !== 6'd10 || raddr !== 6'd1 || empty !== 1'b1) begin
      bad++;
      $display("FAIL wrap_end got=%0d/%0d/%b want=10/1/1", b_rptr, raddr, empty);
    end
  endtask

  task automatic test_full_level();
    do_reset();
    set_in(1'b0, 45);
    tick();
    total++;
    if (rd_level !== 6'd45) begin
      bad++;
      $display("FAIL full_level got=%0d want=45", rd_level);
    end
    for (int i = 0; i < 41; i++) begin
      set_in(1'b1, 45);
      tick();
    end
    set_in(1'b0, 3);
    tick();
    obs = {b_rptr, g_rptr, raddr, empty, rd_level, almost_empty, underflow};
    total++;
    if (obs !== exp_vec()) begin
      bad++;
      $display("FAIL wrapped_vec got=%h want=%h", obs, exp_vec());
    end
    total++;
    if (b_rptr !== 6'd50 || rd_level !== 6'd8) begin
      bad++;
      $display("FAIL wrapped_level got=%0d/%0d want=50/8", b_rptr, rd_level);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    set_in(1'b1, 0);
    tick();
    total++;
    if (underflow !== 1'b1 || b_rptr !== 6'd9) begin
      bad++;
      $display("FAIL uf_set got=%b/%0d want=1/9", underflow, b_rptr);
    end
    for (int i = 0; i < 4; i++) begin
      set_in(i < 3, 3);
      tick();
      obs = {b_rptr, g_rptr, raddr, empty, rd_level, almost_empty, underflow};
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL uf_hold[%0d] got=%h want=%h", i, obs, exp_vec());
      end
    end
    total++;
    if (underflow !== 1'b1) begin
      bad++;
      $display("FAIL uf_sticky got=%b want=1", underflow);
    end
  endtask

  task automatic test_random();
    int occ;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      occ = ring(m_wslot - m_rslot);
      set_in(($urandom_range(0, 3) != 0), m_wslot + $urandom_range(0, 45 - occ) / 8);
      tick();
      obs = {b_rptr, g_rptr, raddr, empty, rd_level, almost_empty, underflow};
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL random[%0d] got=%h want=%h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 21; i++) begin
      set_in(1'b1, 40);
      tick();
    end
    total++;
    if (b_rptr !== 6'd30) begin
      bad++;
      $display("FAIL mid_pre got=%0d want=30", b_rptr);
    end
    set_in(1'b1, 40);
    #2;
    rst_n = 1'b0;
    set_in(1'b1, 0);
    model_reset();
    #1;
    obs = {b_rptr, g_rptr, raddr, empty, rd_level, almost_empty, underflow};
    total++;
    if (obs !== exp_vec()) begin
      bad++;
      $display("FAIL mid_async got=%h want=%h", obs, exp_vec());
    end
    tick();
    tick();
    rst_n = 1'b1;
    set_in(1'b1, 3);
    tick();
    total++;
    if (b_rptr !== 6'd10 || underflow !== 1'b0) begin
      bad++;
      $display("FAIL mid_release got=%0d/%b want=10/0", b_rptr, underflow);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    set_in(1'b0, 0);
    model_reset();
    #1;
    test_reset();
    test_burst();
    test_wrap();
    test_full_level();
    test_underflow();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
